// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that hands out words from a 32-bit Fibonacci LFSR.
// One LFSR step per delivered word; a warm-up phase follows reset or seed load.
module lfsr_arbiter #(
   parameter int NREQ   = 4,
   parameter int WARMUP = 16
) (
   input  logic            CLK,
   input  logic            RESETH,
   input  logic [NREQ-1:0] REQ,
   input  logic            SEED_WE,
   input  logic [31:0]     SEED,
   output logic [NREQ-1:0] GNT,
   output logic            RVALID,
   output logic [31:0]     RDATA,
   output logic            READY
);

   localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] WCNT_INIT = 8'(WARMUP);

   typedef enum logic {
      ST_WARMUP = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   localparam state_t ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

   state_t          r_state;
   state_t          w_nextState;
   logic [31:0]     r_s;
   logic [31:0]     w_nextS;
   logic [31:0]     w_stepS;
   logic [7:0]      r_wcnt;
   logic [7:0]      w_nextWcnt;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_nextPtr;
   logic [PW-1:0]   w_winner;
   logic            w_found;
   logic            w_grant;
   logic [NREQ-1:0] w_gntOh;
   logic [NREQ-1:0] r_gnt;
   logic            r_rvalid;
   logic [31:0]     r_rdata;

   assign w_stepS = {r_s[0] ^ r_s[9] ^ r_s[29] ^ r_s[30], r_s[31:1]};

   // Search upward from the pointer, wrapping, so the last winner drops to lowest priority.
   always_comb begin
      int idx;
      idx      = 0;
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(r_ptr) + i;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!w_found && REQ[idx]) begin
            w_found  = 1'b1;
            w_winner = PW'(idx);
         end
      end
   end

   always_comb begin
      w_gntOh           = '0;
      w_gntOh[w_winner] = 1'b1;
   end

   // Seed load outranks everything, including a pending grant.
   always_comb begin
      w_nextState = r_state;
      w_nextS     = r_s;
      w_nextWcnt  = r_wcnt;
      w_nextPtr   = r_ptr;
      w_grant     = 1'b0;
      if (SEED_WE) begin
         w_nextS     = (SEED == 32'd0) ? 32'hFFFF_FFFF : SEED;
         w_nextWcnt  = WCNT_INIT;
         w_nextState = ST_INIT;
      end else begin
         case (r_state)
            ST_WARMUP: begin
               w_nextS    = w_stepS;
               w_nextWcnt = r_wcnt - 8'd1;
               if (r_wcnt <= 8'd1) begin
                  w_nextState = ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_found) begin
                  w_grant   = 1'b1;
                  w_nextS   = w_stepS;
                  w_nextPtr = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
               end
            end
            default: w_nextState = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESETH) begin
      if (RESETH) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // RDATA only loads on a grant so it keeps the last delivered word while idle.
   always_ff @(posedge CLK or posedge RESETH) begin
      if (RESETH) begin
         r_s      <= 32'hFFFF_FFFF;
         r_wcnt   <= WCNT_INIT;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= 32'd0;
      end else begin
         r_s      <= w_nextS;
         r_wcnt   <= w_nextWcnt;
         r_ptr    <= w_nextPtr;
         r_gnt    <= w_grant ? w_gntOh : '0;
         r_rvalid <= w_grant;
         if (w_grant) begin
            r_rdata <= r_s;
         end
      end
   end

   assign GNT    = r_gnt;
   assign RVALID = r_rvalid;
   assign RDATA  = r_rdata;
   assign READY  = (r_state == ST_RUN);

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Scoreboard bench for lfsr_arbiter: a reference model queues expected grants,
// a negedge monitor pops and compares them; directed vectors cover warm-up and reset.
module tb_lfsr_arbiter;

   localparam int NREQ = 4;

   typedef struct {
      logic [NREQ-1:0] gnt;
      logic [31:0]     data;
   } grant_t;

   logic            CLK = 1'b0;
   logic            RESETH;
   logic [NREQ-1:0] reqA, gntA, reqB, gntB;
   logic            seedWeA, rvalidA, readyA, seedWeB, rvalidB, readyB;
   logic [31:0]     seedA, rdataA, seedB, rdataB;

   grant_t      expQ[$];
   grant_t      obsQ[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mS;
   int          mPtr;
   logic [31:0] lastData;

   logic [3:0]  rrGnt [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0001};
   logic [31:0] firstWords [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h9FFF_FFFF};

   always #5 CLK = ~CLK;

   lfsr_arbiter #(.NREQ(NREQ), .WARMUP(0)) dutA (
      .CLK(CLK), .RESETH(RESETH), .REQ(reqA), .SEED_WE(seedWeA), .SEED(seedA),
      .GNT(gntA), .RVALID(rvalidA), .RDATA(rdataA), .READY(readyA)
   );

   lfsr_arbiter #(.NREQ(NREQ), .WARMUP(2)) dutB (
      .CLK(CLK), .RESETH(RESETH), .REQ(reqB), .SEED_WE(seedWeB), .SEED(seedB),
      .GNT(gntB), .RVALID(rvalidB), .RDATA(rdataB), .READY(readyB)
   );

   // Generator step as "shift right, insert parity of the tap bits 30, 29, 9, 0 at the top".
   function automatic logic [31:0] stepS(input logic [31:0] s);
      logic [31:0] taps;
      taps = 32'h6000_0201;
      return (s >> 1) | ({31'd0, ^(s & taps)} << 31);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] req, input logic we,
                                input logic [31:0] seed, input logic rst);
      @(negedge CLK);
      #1;
      reqA    = req;
      seedWeA = we;
      seedA   = seed;
      RESETH  = rst;
   endtask

   task automatic resetDut();
      @(negedge CLK);
      #1;
      RESETH  = 1'b1;
      reqA    = '0;
      seedWeA = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      RESETH  = 1'b0;
   endtask

   // Reference model for dutA (no warm-up): what each sampled cycle should deliver.
   always @(posedge CLK or posedge RESETH) begin : model
      grant_t e;
      int     w;
      if (RESETH) begin
         mS   = 32'hFFFF_FFFF;
         mPtr = 0;
         expQ.delete();
      end else if (seedWeA) begin
         mS = (seedA == 32'd0) ? 32'hFFFF_FFFF : seedA;
      end else if (reqA != '0) begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && reqA[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
         end
         e.gnt    = '0;
         e.gnt[w] = 1'b1;
         e.data   = mS;
         expQ.push_back(e);
         mS   = stepS(mS);
         mPtr = (w + 1) % NREQ;
      end
   end

   always @(negedge CLK) begin : monitor
      grant_t e;
      grant_t o;
      if (RESETH) begin
         lastData = 32'd0;
      end else begin
         checkOutput("readyA", 32'(readyA), 32'd1);
         checkOutput("rvalidA", 32'(rvalidA), 32'(expQ.size() != 0));
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            if (rvalidA) begin
               checkOutput("gntA", 32'(gntA), 32'(e.gnt));
               checkOutput("rdataA", rdataA, e.data);
               o.gnt  = gntA;
               o.data = rdataA;
               obsQ.push_back(o);
            end
            lastData = e.data;
         end else begin
            checkOutput("idleGntA", 32'(gntA), 32'd0);
            checkOutput("holdRdataA", rdataA, lastData);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      RESETH  = 1'b1;
      reqA    = '0;
      seedWeA = 1'b0;
      seedA   = 32'd0;
      reqB    = 4'b0001;
      seedWeB = 1'b0;
      seedB   = 32'd0;

      #2;
      checkOutput("rstGntA", 32'(gntA), 32'd0);
      checkOutput("rstRvalidA", 32'(rvalidA), 32'd0);
      checkOutput("rstRdataA", rdataA, 32'd0);
      checkOutput("rstReadyA", 32'(readyA), 32'd1);
      checkOutput("rstReadyB", 32'(readyB), 32'd0);
      repeat (2) @(negedge CLK);
      #1;
      RESETH = 1'b0;

      // dutB: two warm-up cycles, then the first word is the generator after two steps.
      checkOutput("warmReadyB0", 32'(readyB), 32'd0);
      @(negedge CLK);
      checkOutput("warmReadyB1", 32'(readyB), 32'd0);
      checkOutput("warmGntB1", 32'(gntB), 32'd0);
      @(negedge CLK);
      checkOutput("warmReadyB2", 32'(readyB), 32'd1);
      checkOutput("warmGntB2", 32'(gntB), 32'd0);
      @(negedge CLK);
      checkOutput("firstGntB", 32'(gntB), 32'h1);
      checkOutput("firstRvalidB", 32'(rvalidB), 32'd1);
      checkOutput("firstRdataB", rdataB, 32'h3FFF_FFFF);

      // dutB: seed load in the middle of warm-up restarts it from the new seed.
      resetDut();
      @(negedge CLK);
      checkOutput("reseedReadyB0", 32'(readyB), 32'd0);
      #1;
      seedWeB = 1'b1;
      seedB   = 32'h1234_5678;
      @(negedge CLK);
      checkOutput("reseedReadyB1", 32'(readyB), 32'd0);
      checkOutput("reseedRvalidB", 32'(rvalidB), 32'd0);
      #1;
      seedWeB = 1'b0;
      @(negedge CLK);
      checkOutput("reseedReadyB2", 32'(readyB), 32'd0);
      @(negedge CLK);
      checkOutput("reseedReadyB3", 32'(readyB), 32'd1);
      @(negedge CLK);
      checkOutput("reseedGntB", 32'(gntB), 32'h1);
      checkOutput("reseedRdataB", rdataB, 32'hC48D_159E);

      // dutA: single requester gets successive words every cycle.
      resetDut();
      obsQ.delete();
      repeat (4) applyStimulus(4'b0001, 1'b0, 32'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
      checkOutput("soloCount", 32'(obsQ.size()), 32'd4);
      for (int i = 0; i < 4 && i < obsQ.size(); i++) begin
         checkOutput("soloGnt", 32'(obsQ[i].gnt), 32'h1);
         checkOutput("soloData", obsQ[i].data, firstWords[i]);
      end

      // dutA: full contention rotates, then 0101 from PTR=1 picks 2 then 0.
      resetDut();
      obsQ.delete();
      repeat (5) applyStimulus(4'b1111, 1'b0, 32'd0, 1'b0);
      repeat (2) applyStimulus(4'b0101, 1'b0, 32'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
      checkOutput("rrCount", 32'(obsQ.size()), 32'd7);
      for (int i = 0; i < 7 && i < obsQ.size(); i++) begin
         checkOutput("rrGnt", 32'(obsQ[i].gnt), 32'(rrGnt[i]));
      end

      // dutA: seed strobe blocks the grant; zero seed maps to all-ones.
      obsQ.delete();
      applyStimulus(4'b0001, 1'b1, 32'd0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 32'd0, 1'b0);
      applyStimulus(4'b0001, 1'b1, 32'h1234_5678, 1'b0);
      applyStimulus(4'b0001, 1'b0, 32'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
      checkOutput("seedCount", 32'(obsQ.size()), 32'd2);
      if (obsQ.size() >= 2) begin
         checkOutput("seedZeroData", obsQ[0].data, 32'hFFFF_FFFF);
         checkOutput("seedData", obsQ[1].data, 32'h1234_5678);
      end

      // dutA: asynchronous reset between edges kills the visible grant immediately.
      resetDut();
      applyStimulus(4'b0010, 1'b0, 32'd0, 1'b0);
      @(posedge CLK);
      #2;
      checkOutput("preRstGnt", 32'(gntA), 32'h2);
      checkOutput("preRstRvalid", 32'(rvalidA), 32'd1);
      RESETH = 1'b1;
      #1;
      checkOutput("asyncRstGnt", 32'(gntA), 32'd0);
      checkOutput("asyncRstRvalid", 32'(rvalidA), 32'd0);
      checkOutput("asyncRstRdata", rdataA, 32'd0);
      reqA = '0;
      @(negedge CLK);
      #1;
      RESETH = 1'b0;
      obsQ.delete();
      applyStimulus(4'b0001, 1'b0, 32'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
      checkOutput("postRstCount", 32'(obsQ.size()), 32'd1);
      if (obsQ.size() >= 1) begin
         checkOutput("postRstData", obsQ[0].data, 32'hFFFF_FFFF);
      end

      // dutA: random requests, seeds (some zero) and occasional reset pulses.
      resetDut();
      for (int n = 0; n < 400; n++) begin
         logic [NREQ-1:0] req;
         logic            we;
         logic [31:0]     seed;
         logic            rst;
         req  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15));
         we   = ($urandom_range(0, 15) == 0);
         seed = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
         rst  = ($urandom_range(0, 63) == 0);
         applyStimulus(req, we, seed, rst);
      end
      applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 32'd0, 1'b0);
      checkOutput("drainA", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter WARMUP, default 16: generator steps to run after reset or seed load before grants are allowed, 0..255.
REQ-003 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-004 SHALL have port RESETH, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port REQ, input, NREQ: per-requester random-word request, level-sensitive.
REQ-006 SHALL have port SEED_WE, input, 1: load-seed strobe.
REQ-007 SHALL have port SEED, input, 32: seed value, sampled when SEED_WE=1.
REQ-008 SHALL have port GNT, output, NREQ: registered one-hot grant, asserted for one cycle per delivered word.
REQ-009 SHALL have port RVALID, output, 1: registered; high exactly when GNT is non-zero.
REQ-010 SHALL have port RDATA, output, 32: registered random word; valid when RVALID=1.
REQ-011 SHALL have port READY, output, 1: high in state RUN.

Function
REQ-012 SHALL contain a 32-bit generator register S; one step SHALL set S to {S[0]^S[9]^S[29]^S[30], S[31:1]}.
REQ-013 SHALL implement FSM states WARMUP and RUN, plus a counter WCNT of 8 bits and a round-robin pointer PTR of ceil(log2 NREQ) bits.
REQ-014 WARMUP: each cycle, step S and decrement WCNT; when WCNT==1, go to RUN; GNT, RVALID = 0.
REQ-015 RUN, no REQ bit set, no SEED_WE: S, PTR hold; GNT=0, RVALID=0 next cycle.
REQ-016 RUN, any REQ bit set, no SEED_WE: winner = first set REQ bit searching from index PTR upward, wrapping past NREQ-1 to 0.
REQ-017 On a grant, the next edge SHALL register GNT=one-hot(winner), RVALID=1, RDATA=S (pre-step value); step S once; set PTR=(winner+1) mod NREQ.
REQ-018 Latency SHALL be one cycle from sampled REQ to GNT/RDATA; a requester holding REQ alone SHALL be granted every cycle with successive words.
REQ-019 No two grants SHALL ever return the same generator state consecutively; each grant consumes exactly one step.
REQ-020 SEED_WE=1 in any state SHALL take priority over grants: next edge S = SEED, or 32'hFFFFFFFF if SEED==0; no grant that cycle; PTR unchanged.
REQ-021 After seed load, state SHALL be WARMUP with WCNT=WARMUP, or RUN directly if WARMUP==0.
REQ-022 SEED_WE during WARMUP SHALL restart warm-up from the new seed.
REQ-023 RDATA SHALL hold its last value when RVALID=0.
REQ-024 REQ bits at index >= NREQ do not exist; PTR SHALL never exceed NREQ-1.

Reset
REQ-025 RESETH=1 SHALL immediately (asynchronously) set S=32'hFFFFFFFF, PTR=0, GNT=0, RVALID=0, RDATA=0, WCNT=WARMUP.
REQ-026 Reset state SHALL be WARMUP, or RUN if WARMUP==0; READY reflects that state during and after reset.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight grant; no GNT pulse SHALL appear in the cycle after reset release unless REQ was sampled in RUN.

Verification
REQ-028 WARMUP=0, reset release, REQ=0001 held 3 cycles -> GNT=0001 each cycle, RDATA = FFFFFFFF, 7FFFFFFF, 3FFFFFFF, then 9FFFFFFF on a 4th cycle.
REQ-029 WARMUP=0, NREQ=4, REQ=1111 held 5 cycles -> GNT = 0001, 0010, 0100, 1000, 0001; RVALID=1 throughout.
REQ-030 After grant to requester 0 (PTR=1), REQ=0101 held -> GNT = 0100 then 0001.
REQ-031 SEED_WE=1 with SEED=0 and REQ=0001 in same cycle -> no grant that cycle; next grant RDATA=FFFFFFFF; SEED=12345678 -> next grant RDATA=12345678.
REQ-032 WARMUP=2, reset release, REQ=0001 held -> READY low 2 cycles, first grant RDATA=3FFFFFFF.
REQ-033 RESETH pulsed asynchronously between edges while GNT=0010 -> GNT, RVALID, RDATA go to 0 before next edge; S restarts at FFFFFFFF.
